// File: rtl/imem_fetch_if.sv
// Purpose : bundles the instruction-memory port and the fetch-to-IF/ID handshake into one bus.
// Latency : none (wires only).
// Backpressure: out_ready from the consumer; master = fetch controller, slave = memory/consumer side.
// Ports   : imem_adr/imem_inst (memory), redirect_valid/redirect_pc/halt (control in),
//           out_valid/out_ready/out_inst/out_pc (fetched-word stream), fault/fetch_cnt (status).
interface imem_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic [ADDR_W-1:0] imem_adr;
    logic [WORD_W-1:0] imem_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              fault;
    logic [31:0]       fetch_cnt;

    modport master (
        output imem_adr, out_valid, out_inst, out_pc, fault, fetch_cnt,
        input  imem_inst, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_adr, out_valid, out_inst, out_pc, fault, fetch_cnt,
        output imem_inst, redirect_valid, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Purpose : PC sequencer for a combinational instruction memory, feeding a 2-entry in-order queue.
// Latency : word at PC appears on out_* the cycle after it is fetched (1 cycle).
// Backpressure: fetch stalls when the queue is full and the head is not being popped; head held stable.
// Ports   : clk, rst (sync, active high), bus (imem_fetch_if.master: memory port, redirect/halt
//           controls, out_* valid/ready stream, sticky fault, fetch_cnt push counter).
module imem_fetch_ctrl #(
    parameter int              ADDR_W    = 32,
    parameter int              WORD_W    = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    imem_fetch_if.master  bus
);
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic [WORD_W-1:0] head_inst, tail_inst;
    logic [ADDR_W-1:0] head_pc, tail_pc;
    logic [31:0]       fetch_cnt;

    logic pc_ok, pop, space, push;

    assign pc_ok = (pc < MEM_LIMIT);
    assign pop   = (count != 2'd0) & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign space = (count < 2'd2) | pop;
    assign push  = (state == RUN) & ~bus.halt & ~bus.redirect_valid & pc_ok & space;

    assign bus.imem_adr  = pc;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_inst  = head_inst;
    assign bus.out_pc    = head_pc;
    assign bus.fault     = (state == FAULT);
    assign bus.fetch_cnt = fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            count     <= 2'd0;
            head_inst <= '0;
            head_pc   <= '0;
            tail_inst <= '0;
            tail_pc   <= '0;
            fetch_cnt <= 32'd0;
        end else if (bus.redirect_valid) begin
            // Flush: entries (including one popped this cycle) are dropped; the head
            // registers keep their old contents so out_* hold their last value.
            pc    <= bus.redirect_pc;
            count <= 2'd0;
            state <= (bus.redirect_pc < MEM_LIMIT) ? RUN : FAULT;
        end else begin
            if ((state == RUN) && !pc_ok)
                state <= FAULT;

            if (push) begin
                pc        <= pc + 1'b1;
                fetch_cnt <= fetch_cnt + 32'd1;
            end

            unique case (count)
                2'd0: begin
                    if (push) begin
                        head_inst <= bus.imem_inst;
                        head_pc   <= pc;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_inst <= bus.imem_inst;
                        head_pc   <= pc;
                    end else if (push) begin
                        tail_inst <= bus.imem_inst;
                        tail_pc   <= pc;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: push is only possible together with a pop.
                    if (pop) begin
                        head_inst <= tail_inst;
                        head_pc   <= tail_pc;
                        if (push) begin
                            tail_inst <= bus.imem_inst;
                            tail_pc   <= pc;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
    localparam int MW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_if #(.ADDR_W(32), .WORD_W(32)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W(32), .WORD_W(32), .MEM_WORDS(MW), .RESET_PC(32'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [31:0] mem [MW];
    assign bus.imem_inst = (bus.imem_adr < MW) ? mem[bus.imem_adr[5:0]] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of delivered-but-unconsumed words plus PC/fault/count.
    typedef struct packed {logic [31:0] inst; logic [31:0] pc;} ent_t;
    ent_t        q[$];
    ent_t        m_last;
    logic [31:0] m_pc;
    bit          m_fault;
    logic [31:0] m_cnt;

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc,
                        input bit h, input bit rdy);
        bit   pop, push;
        ent_t e;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = h;
        bus.out_ready      = rdy;
        if (r) begin
            q.delete(); m_pc = 32'd0; m_fault = 0; m_cnt = 32'd0; m_last = '0;
        end else begin
            pop = (q.size() > 0) && rdy;
            if (rv) begin
                q.delete();
                m_pc    = rpc;
                m_fault = (rpc >= MW);
            end else begin
                push = !m_fault && !h && (m_pc < MW) && ((q.size() < 2) || pop);
                if (pop) void'(q.pop_front());
                if (push) begin
                    e.inst = mem[m_pc[5:0]];
                    e.pc   = m_pc;
                    q.push_back(e);
                    m_pc  = m_pc + 1;
                    m_cnt = m_cnt + 1;
                end
                if (m_pc >= MW && !push) m_fault = 1;
            end
            if (q.size() > 0) m_last = q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'd0) begin errors++; $display("FAIL reset_inst got %h want 0", bus.out_inst); end
        checks++; if (bus.out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", bus.out_pc); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", bus.fault); end
        checks++; if (bus.fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.fetch_cnt); end
        checks++; if (bus.imem_adr !== 32'd0) begin errors++; $display("FAIL reset_adr got %0d want 0", bus.imem_adr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0, 1);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k-1) || bus.out_inst !== mem[k-1])
                begin errors++; $display("FAIL b2b_word%0d got v=%0b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                    k, bus.out_valid, bus.out_pc, bus.out_inst, k-1, mem[k-1]); end
        end
        checks++; if (bus.fetch_cnt !== 32'd4) begin errors++; $display("FAIL b2b_cnt got %0d want 4", bus.fetch_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0);
            checks++; if (bus.out_inst !== mem[0] || bus.out_pc !== 32'd0 || bus.out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold got pc=%0d inst=%h want pc=0 inst=%h", bus.out_pc, bus.out_inst, mem[0]); end
        end
        checks++; if (bus.fetch_cnt !== 32'd2 || bus.imem_adr !== 32'd2)
            begin errors++; $display("FAIL bp_stall got cnt=%0d pc=%0d want cnt=2 pc=2", bus.fetch_cnt, bus.imem_adr); end
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 1);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k) || bus.out_inst !== mem[k])
                begin errors++; $display("FAIL bp_release%0d got pc=%0d inst=%h want pc=%0d inst=%h",
                    k, bus.out_pc, bus.out_inst, k, mem[k]); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 32'd40, 0, 0);
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_adr !== 32'd40)
            begin errors++; $display("FAIL redir_flush got v=%0b pc=%0d want v=0 pc=40", bus.out_valid, bus.imem_adr); end
        step(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd40 || bus.out_inst !== mem[40])
            begin errors++; $display("FAIL redir_target got v=%0b pc=%0d inst=%h want v=1 pc=40 inst=%h",
                bus.out_valid, bus.out_pc, bus.out_inst, mem[40]); end
    endtask

    task automatic test_fault_end();
        do_reset();
        step(0, 1, MW-3, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(MW-1) || bus.out_inst !== mem[MW-1])
            begin errors++; $display("FAIL end_last got v=%0b pc=%0d want v=1 pc=%0d", bus.out_valid, bus.out_pc, MW-1); end
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        checks++; if (bus.fault !== 1'b1 || bus.fetch_cnt !== 32'd3 || bus.out_valid !== 1'b0 || bus.imem_adr !== 32'(MW))
            begin errors++; $display("FAIL end_fault got f=%0b cnt=%0d v=%0b pc=%0d want f=1 cnt=3 v=0 pc=%0d",
                bus.fault, bus.fetch_cnt, bus.out_valid, bus.imem_adr, MW); end
        step(0, 1, 32'd5, 0, 1);
        checks++; if (bus.fault !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL end_recover got f=%0b v=%0b want f=0 v=0", bus.fault, bus.out_valid); end
        step(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd5 || bus.out_inst !== mem[5])
            begin errors++; $display("FAIL end_resume got v=%0b pc=%0d want v=1 pc=5", bus.out_valid, bus.out_pc); end
        step(0, 1, 32'd200, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_adr !== 32'd200)
            begin errors++; $display("FAIL oob_redirect got f=%0b v=%0b pc=%0d want f=1 v=0 pc=200",
                bus.fault, bus.out_valid, bus.imem_adr); end
    endtask

    task automatic test_halt();
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 1, 1);
            checks++; if (bus.imem_adr !== 32'd2 || bus.out_valid !== (k == 1))
                begin errors++; $display("FAIL halt_c%0d got pc=%0d v=%0b want pc=2 v=%0b",
                    k, bus.imem_adr, bus.out_valid, (k == 1)); end
        end
        checks++; if (bus.fetch_cnt !== 32'd2) begin errors++; $display("FAIL halt_cnt got %0d want 2", bus.fetch_cnt); end
        step(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd2 || bus.out_inst !== mem[2])
            begin errors++; $display("FAIL halt_resume got v=%0b pc=%0d want v=1 pc=2", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_adr !== 32'd0 || bus.fetch_cnt !== 32'd0 || bus.fault !== 1'b0)
            begin errors++; $display("FAIL midrst got v=%0b pc=%0d cnt=%0d f=%0b want 0 0 0 0",
                bus.out_valid, bus.imem_adr, bus.fetch_cnt, bus.fault); end
    endtask

    task automatic test_random();
        ent_t exp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit rv, h, rdy, r;
            r   = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            h   = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rv, 32'($urandom_range(0, MW + 3)), h, rdy);
            exp = (q.size() > 0) ? q[0] : m_last;
            checks++; if (bus.out_valid !== (q.size() > 0) || bus.out_pc !== exp.pc || bus.out_inst !== exp.inst
                          || bus.fault !== m_fault || bus.fetch_cnt !== m_cnt || bus.imem_adr !== m_pc)
                begin errors++; $display("FAIL rand_%0d got v=%0b pc=%0d inst=%h f=%0b cnt=%0d adr=%0d want v=%0b pc=%0d inst=%h f=%0b cnt=%0d adr=%0d",
                    n, bus.out_valid, bus.out_pc, bus.out_inst, bus.fault, bus.fetch_cnt, bus.imem_adr,
                    (q.size() > 0), exp.pc, exp.inst, m_fault, m_cnt, m_pc); end
        end
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect();
        test_fault_end();
        test_halt();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
